div_share_arbiter: RTL and testbench

- Shares one 16-bit sequential divider (`devision_seq_board`, start/done handshake) among NUM_REQ requesters.
- Arbitrates round-robin and sequences each operation: clear, start, wait for done, return quotient/remainder.
- Short-circuits divide-by-zero without using the divider.
- Bounds every divider run with a timeout. Sits between requester logic and the single divider instance.

---
 rtl/div_arb_pkg.sv | 25 ++
 rtl/div_share_arbiter_if.sv | 46 ++++
 rtl/div_share_arbiter_rr_pick.sv | 40 ++++
 rtl/div_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
// +------------------------------------------------------------------+
// | div_arb_pkg: shared types and constants for div_share_arbiter      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int DEF_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/div_share_arbiter_if.sv
// +------------------------------------------------------------------+
// | div_share_arbiter_if: requester and divider side signal bundle     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

interface div_share_arbiter_if
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_y;
  logic [WIDTH-1:0]         rsp_rem;
  logic [1:0]               rsp_err;
  logic                     busy;
  logic                     div_clr;
  logic                     div_start;
  logic [WIDTH-1:0]         div_a;
  logic [WIDTH-1:0]         div_b;
  logic                     div_done;
  logic [WIDTH-1:0]         div_y;
  logic [WIDTH-1:0]         div_rem;

  // Environment view: requesters plus the divider instance.
  modport master (
    output req, a_in, b_in, div_done, div_y, div_rem,
    input  rsp_valid, rsp_y, rsp_rem, rsp_err, busy,
           div_clr, div_start, div_a, div_b
  );

  // Arbiter view.
  modport slave (
    input  req, a_in, b_in, div_done, div_y, div_rem,
    output rsp_valid, rsp_y, rsp_rem, rsp_err, busy,
           div_clr, div_start, div_a, div_b
  );

endinterface

`default_nettype wire

// File: rtl/div_share_arbiter_rr_pick.sv
// +------------------------------------------------------------------+
// | rr_pick: combinational round-robin selector, search from last+1    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDXW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   w_mask;
  logic [2*NUM_REQ-1:0] w_dbl;

  // Lower copy keeps only positions above last_grant; upper copy wraps around.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (i > int'(last_grant));
    end
    w_dbl = {req, req & w_mask};
    idx   = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (w_dbl[i]) idx = IDXW'(i % NUM_REQ);
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/div_share_arbiter.sv
// +------------------------------------------------------------------+
// | div_share_arbiter: round-robin sharing of one sequential divider   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  div_share_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_nx;
  logic [IDXW-1:0]    r_idx, w_idx_nx;
  logic [IDXW-1:0]    r_last, w_last_nx;
  logic [IDXW-1:0]    w_pick;
  logic               w_any;
  logic [WIDTH-1:0]   r_a, w_a_nx, r_b, w_b_nx;
  logic [WIDTH-1:0]   r_y, w_y_nx, r_rem, w_rem_nx;
  logic [1:0]         r_err, w_err_nx;
  logic [CNTW-1:0]    r_cnt, w_cnt_nx;
  logic [NUM_REQ-1:0] r_valid, w_valid_nx;
  logic               r_busy, r_clr, r_start;
  logic [WIDTH-1:0]   w_a_arr [NUM_REQ];
  logic [WIDTH-1:0]   w_b_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ    (NUM_REQ)
  ) u_pick (
    .req        (bus.req),
    .last_grant (r_last),
    .any        (w_any),
    .idx        (w_pick)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i] = bus.a_in[i*WIDTH +: WIDTH];
      w_b_arr[i] = bus.b_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_y_nx     = r_y;
    w_rem_nx   = r_rem;
    w_err_nx   = r_err;
    w_cnt_nx   = r_cnt;
    w_valid_nx = '0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_idx_nx = w_pick;
          w_a_nx   = w_a_arr[w_pick];
          w_b_nx   = w_b_arr[w_pick];
          if (w_b_arr[w_pick] == '0) begin
            w_y_nx     = '1;
            w_rem_nx   = w_a_arr[w_pick];
            w_err_nx   = ERR_DIV0;
            w_state_nx = RESP;
          end else begin
            w_state_nx = CLR;
          end
        end
      end
      CLR: begin
        w_state_nx = START;
      end
      START: begin
        w_cnt_nx   = '0;
        w_state_nx = WAIT;
      end
      WAIT: begin
        // done takes precedence over a coincident timeout
        if (bus.div_done) begin
          w_y_nx     = bus.div_y;
          w_rem_nx   = bus.div_rem;
          w_err_nx   = ERR_OK;
          w_state_nx = RESP;
        end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_y_nx     = '0;
          w_rem_nx   = '0;
          w_err_nx   = ERR_TIMEOUT;
          w_state_nx = RESP;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RESP: begin
        w_last_nx  = r_idx;
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid_nx[i] = (w_state_nx == RESP) && (w_idx_nx == IDXW'(i));
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= IDXW'(NUM_REQ - 1);
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_rem   <= '0;
      r_err   <= ERR_OK;
      r_cnt   <= '0;
      r_valid <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_y     <= w_y_nx;
      r_rem   <= w_rem_nx;
      r_err   <= w_err_nx;
      r_cnt   <= w_cnt_nx;
      r_valid <= w_valid_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_clr   <= (w_state_nx == CLR);
      r_start <= (w_state_nx == START);
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_y     = r_y;
  assign bus.rsp_rem   = r_rem;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = r_busy;
  assign bus.div_clr   = r_clr;
  assign bus.div_start = r_start;
  assign bus.div_a     = r_a;
  assign bus.div_b     = r_b;

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// +------------------------------------------------------------------+
// | tb_div_share_arbiter: directed bench with a behavioural divider    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_div_share_arbiter;
  import div_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int DV_LAT  = 17;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic hang = 1'b0;
  int   cyc  = 0;
  int   n_chk = 0;
  int   n_err = 0;

  div_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  div_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: cleared by rst or div_clr, done rises DV_LAT cycles after start.
  logic             dv_rst;
  logic             dv_run;
  int               dv_cnt;
  logic [WIDTH-1:0] dv_a, dv_b;
  assign dv_rst = rst | bus.div_clr;

  always @(posedge clk or posedge dv_rst) begin
    if (dv_rst) begin
      dv_run <= 1'b0; dv_cnt <= 0; dv_a <= '0; dv_b <= '0;
      bus.div_done <= 1'b0; bus.div_y <= '0; bus.div_rem <= '0;
    end else if (bus.div_start) begin
      dv_run <= 1'b1; dv_cnt <= 0; dv_a <= bus.div_a; dv_b <= bus.div_b;
      bus.div_done <= 1'b0;
    end else if (dv_run && !hang) begin
      if (dv_cnt == DV_LAT - 1) begin
        dv_run <= 1'b0;
        bus.div_done <= 1'b1;
        bus.div_y    <= dv_a / dv_b;
        bus.div_rem  <= dv_a % dv_b;
      end else begin
        dv_cnt <= dv_cnt + 1;
      end
    end
  end

  int   lg_idx[$], lg_y[$], lg_rem[$], lg_err[$], lg_lat[$], lg_dlat[$];
  int   remaining [NUM_REQ];
  int   grant_cyc, done_cyc, clr_cyc;
  int   n_clr, n_start, n_multi, bad_order;
  logic prev_busy, prev_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    lg_idx.delete(); lg_y.delete(); lg_rem.delete();
    lg_err.delete(); lg_lat.delete(); lg_dlat.delete();
    n_clr = 0; n_start = 0; n_multi = 0; bad_order = 0; clr_cyc = -10;
  endtask

  // Advance to the next falling edge, observe outputs, retire finished requesters.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) grant_cyc = cyc;
      prev_busy = bus.busy;
      if (bus.div_done && !prev_done) done_cyc = cyc;
      prev_done = bus.div_done;
      if (bus.div_clr) begin n_clr++; clr_cyc = cyc; end
      if (bus.div_start) begin
        n_start++;
        if (clr_cyc != cyc - 1) bad_order++;
      end
      if ($countones(bus.rsp_valid) > 1) n_multi++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.rsp_valid[i]) begin
          lg_idx.push_back(i);
          lg_y.push_back(int'(bus.rsp_y));
          lg_rem.push_back(int'(bus.rsp_rem));
          lg_err.push_back(int'(bus.rsp_err));
          lg_lat.push_back(cyc - grant_cyc + 2);
          lg_dlat.push_back(cyc - done_cyc);
          if (remaining[i] > 0) remaining[i]--;
          if (remaining[i] == 0) bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input int n);
    bus.a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
    remaining[i] = n;
    bus.req[i]   = 1'b1;
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int k = 0;
    while (lg_idx.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rsp_count", lg_idx.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (3) tick();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
    grant_cyc = 0; done_cyc = 0; prev_busy = 1'b0; prev_done = 1'b0;
    clear_log();

    repeat (3) tick();
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_clr",   bus.div_clr, 0);
    chk("rst_start", bus.div_start, 0);
    chk("rst_y",     bus.rsp_y, 0);
    chk("rst_rem",   bus.rsp_rem, 0);
    chk("rst_err",   bus.rsp_err, 0);
    chk("rst_div_a", bus.div_a, 0);
    chk("rst_div_b", bus.div_b, 0);
    rst = 1'b0;
    clear_log();

    // single operation
    set_req(0, 110, 25, 1);
    wait_rsps(1, 100);
    repeat (6) tick();
    chk("single_count", lg_idx.size(), 1);
    chk("single_idx",   lg_idx[0], 0);
    chk("single_y",     lg_y[0], 4);
    chk("single_rem",   lg_rem[0], 10);
    chk("single_err",   lg_err[0], ERR_OK);
    chk("single_done2rsp", lg_dlat[0], 1);
    chk("single_nclr",  n_clr, 1);
    chk("single_nstart", n_start, 1);
    chk("single_order", bad_order, 0);

    // contention from reset: req0 has priority
    do_reset();
    set_req(0, 32200, 37, 1);
    set_req(1, 1234, 56, 1);
    wait_rsps(2, 200);
    chk("cont_idx0", lg_idx[0], 0);
    chk("cont_y0",   lg_y[0], 870);
    chk("cont_rem0", lg_rem[0], 10);
    chk("cont_idx1", lg_idx[1], 1);
    chk("cont_y1",   lg_y[1], 22);
    chk("cont_rem1", lg_rem[1], 2);
    chk("cont_onehot", n_multi, 0);

    // fairness: three requesters held for two operations each
    do_reset();
    set_req(0, 100, 7, 2);
    set_req(1, 200, 9, 2);
    set_req(2, 300, 11, 2);
    wait_rsps(6, 400);
    chk("fair_0", lg_idx[0], 0);
    chk("fair_1", lg_idx[1], 1);
    chk("fair_2", lg_idx[2], 2);
    chk("fair_3", lg_idx[3], 0);
    chk("fair_4", lg_idx[4], 1);
    chk("fair_5", lg_idx[5], 2);
    chk("fair_y0", lg_y[0], 14);
    chk("fair_y1", lg_y[1], 22);
    chk("fair_rem2", lg_rem[2], 3);
    chk("fair_onehot", n_multi, 0);

    // divide by zero
    repeat (2) tick();
    clear_log();
    set_req(2, 500, 0, 1);
    wait_rsps(1, 50);
    chk("div0_idx", lg_idx[0], 2);
    chk("div0_y",   lg_y[0], 32'hFFFF);
    chk("div0_rem", lg_rem[0], 500);
    chk("div0_err", lg_err[0], ERR_DIV0);
    chk("div0_lat", lg_lat[0], 2);
    chk("div0_nstart", n_start, 0);

    // timeout with a divider that never finishes, then a normal op
    repeat (2) tick();
    clear_log();
    hang = 1'b1;
    set_req(3, 1000, 3, 1);
    wait_rsps(1, 200);
    chk("to_idx", lg_idx[0], 3);
    chk("to_y",   lg_y[0], 0);
    chk("to_rem", lg_rem[0], 0);
    chk("to_err", lg_err[0], ERR_TIMEOUT);
    chk("to_lat", lg_lat[0], TIMEOUT + 4);
    hang = 1'b0;
    repeat (2) tick();
    clear_log();
    set_req(3, 1000, 3, 1);
    wait_rsps(1, 100);
    chk("after_to_y",   lg_y[0], 333);
    chk("after_to_rem", lg_rem[0], 1);
    chk("after_to_err", lg_err[0], ERR_OK);

    // reset while waiting on the divider
    repeat (2) tick();
    clear_log();
    hang = 1'b1;
    set_req(0, 5000, 7, 1);
    set_req(1, 99, 9, 1);
    repeat (20) tick();
    chk("abort_norsp", lg_idx.size(), 0);
    chk("abort_busy_pre", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",  bus.busy, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    chk("abort_div_a", bus.div_a, 0);
    chk("abort_y",     bus.rsp_y, 0);
    chk("abort_rem",   bus.rsp_rem, 0);
    repeat (3) tick();
    chk("abort_norsp_rst", lg_idx.size(), 0);
    hang = 1'b0;
    rst  = 1'b0;
    wait_rsps(2, 200);
    chk("rearb_idx0", lg_idx[0], 0);
    chk("rearb_y0",   lg_y[0], 714);
    chk("rearb_rem0", lg_rem[0], 2);
    chk("rearb_idx1", lg_idx[1], 1);
    chk("rearb_y1",   lg_y[1], 11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
